// File: rtl/ahb_slave_ram_if.sv
// AHB slave-side bus bundle for ahb_slave_ram: address/data phase inputs plus the
// slave's HRDATA/HREADYOUT/HRESP outputs.
interface ahb_slave_ram_if #(
  parameter int DATA_WDT = 32
);
  logic                i_hsel;
  logic [31:0]         i_haddr;
  logic [1:0]          i_htrans;
  logic                i_hwrite;
  logic [2:0]          i_hsize;
  logic [2:0]          i_hburst;
  logic [DATA_WDT-1:0] i_hwdata;
  logic                i_hready;
  logic [DATA_WDT-1:0] o_hrdata;
  logic                o_hreadyout;
  logic [1:0]          o_hresp;

  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
    output o_hrdata, o_hreadyout, o_hresp
  );

  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
    input  o_hrdata, o_hreadyout, o_hresp
  );
endinterface

// File: rtl/ahb_slave_ram.sv
// AHB-Lite style slave backed by a byte-lane register array with WAIT_STATES wait cycles.
// Define AHB_SLAVE_RAM_ERR_EN to enable two-cycle ERROR responses for bad size/alignment/range.
module ahb_slave_ram_lane #(
  parameter int ADDR_WDT = 10
)(
  input  logic                i_hclk,
  input  logic                we,
  input  logic [ADDR_WDT-1:0] idx,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata
);
  logic [7:0] mem [2**ADDR_WDT];

  always_ff @(posedge i_hclk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module ahb_slave_ram #(
  parameter int DATA_WDT    = 32,
  parameter int ADDR_WDT    = 10,
  parameter int WAIT_STATES = 0
)(
  input  logic           i_hclk,
  input  logic           i_hreset_n,
  ahb_slave_ram_if.slave bus
);
  localparam int NUM_LANES = DATA_WDT / 8;
  localparam int OFS       = $clog2(NUM_LANES);
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  typedef struct packed {
    logic [ADDR_WDT-1:0] idx;
    logic [OFS-1:0]      ofs;
    logic [2:0]          size;
    logic                write;
    logic                err;
  } req_t;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            wait_cnt;
  req_t                        req_q, req_d;
  logic                        acc, own_free, err_flag;
  logic [2:0]                  size_in;
  logic [OFS-1:0]              ofs_in, mask_q;
  logic [NUM_LANES-1:0]        lane_we;
  logic [NUM_LANES-1:0][7:0]   rbytes;
  logic                        unused_ok;

  // Offset bits below the transfer size, i.e. the bits that must be zero when aligned.
  function automatic logic [OFS-1:0] size_mask(input logic [2:0] s);
    size_mask = '0;
    for (int b = 0; b < OFS; b++) size_mask[b] = (b < 32'(s));
  endfunction

  assign own_free = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign acc      = bus.i_hsel & bus.i_hready & bus.i_htrans[1] & own_free;

`ifdef AHB_SLAVE_RAM_ERR_EN
  assign size_in  = bus.i_hsize;
  assign ofs_in   = bus.i_haddr[OFS-1:0];
  assign err_flag = (32'(bus.i_hsize) > OFS) ||
                    (|(bus.i_haddr[OFS-1:0] & size_mask(bus.i_hsize))) ||
                    (|bus.i_haddr[31:OFS+ADDR_WDT]);
`else
  // Oversized transfers collapse to a full bus word; the offset is forced aligned.
  assign size_in  = (32'(bus.i_hsize) > OFS) ? 3'(OFS) : bus.i_hsize;
  assign ofs_in   = bus.i_haddr[OFS-1:0] & ~size_mask(size_in);
  assign err_flag = 1'b0;
`endif

  assign unused_ok = ^{bus.i_hburst, bus.i_htrans[0], bus.i_haddr[31:OFS+ADDR_WDT]};

  assign req_d = '{idx:   bus.i_haddr[OFS+ADDR_WDT-1:OFS],
                   ofs:   ofs_in,
                   size:  size_in,
                   write: bus.i_hwrite,
                   err:   err_flag};

  always_ff @(posedge i_hclk or negedge i_hreset_n)
    if (!i_hreset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      req_q    <= '0;
    end else begin
      state <= state_nxt;
      if (acc) req_q <= req_d;
      if (state_nxt == S_WAIT && state != S_WAIT) wait_cnt <= CNT_W'(WAIT_STATES - 1);
      else if (state == S_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
    end

  // S_DATA and S_ERR2 both end their data phase this cycle, so they accept like S_IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: if (wait_cnt == '0) state_nxt = S_DATA;
`ifdef AHB_SLAVE_RAM_ERR_EN
      S_ERR1: state_nxt = S_ERR2;
`endif
      default:
        if (acc) begin
          if (err_flag)             state_nxt = S_ERR1;
          else if (WAIT_STATES > 0) state_nxt = S_WAIT;
          else                      state_nxt = S_DATA;
        end else                    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_hreadyout = 1'b1;
    bus.o_hresp     = 2'b00;
    bus.o_hrdata    = '0;
    case (state)
      S_WAIT: bus.o_hreadyout = 1'b0;
      S_DATA: bus.o_hrdata    = rbytes;
`ifdef AHB_SLAVE_RAM_ERR_EN
      S_ERR1: begin bus.o_hreadyout = 1'b0; bus.o_hresp = 2'b01; end
      S_ERR2: bus.o_hresp = 2'b01;
`endif
      default: ;
    endcase
  end

  assign mask_q = size_mask(req_q.size);

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      // A lane is written when it falls inside the size-aligned group holding the offset.
      assign lane_we[g] = (state == S_DATA) & req_q.write & ~req_q.err &
                          ((OFS'(g) & ~mask_q) == req_q.ofs);
      ahb_slave_ram_lane #(.ADDR_WDT(ADDR_WDT)) u_lane (
        .i_hclk (i_hclk),
        .we     (lane_we[g]),
        .idx    (req_q.idx),
        .wdata  (bus.i_hwdata[g*8 +: 8]),
        .rdata  (rbytes[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_ahb_slave_ram.sv
// Scoreboard bench for ahb_slave_ram: two instances (0 and 2 wait states) driven by a
// pipelined master; expected responses come from a word-level reference memory.
module tb_ahb_slave_ram;
  localparam int AW  = 10;
  localparam int WS0 = 0;
  localparam int WS1 = 2;

  logic i_hclk = 1'b0;
  logic i_hreset_n = 1'b1;
  always #5 i_hclk = ~i_hclk;

  logic [1:0]       hsel, hwrite, rdy;
  logic [1:0][31:0] haddr, hwdata, rdata;
  logic [1:0][1:0]  htrans, resp;
  logic [1:0][2:0]  hsize;
  logic [2:0]       hburst;

  ahb_slave_ram_if #(.DATA_WDT(32)) bus0();
  ahb_slave_ram_if #(.DATA_WDT(32)) bus1();

  assign bus0.i_hsel = hsel[0];     assign bus1.i_hsel = hsel[1];
  assign bus0.i_haddr = haddr[0];   assign bus1.i_haddr = haddr[1];
  assign bus0.i_htrans = htrans[0]; assign bus1.i_htrans = htrans[1];
  assign bus0.i_hwrite = hwrite[0]; assign bus1.i_hwrite = hwrite[1];
  assign bus0.i_hsize = hsize[0];   assign bus1.i_hsize = hsize[1];
  assign bus0.i_hburst = hburst;    assign bus1.i_hburst = hburst;
  assign bus0.i_hwdata = hwdata[0]; assign bus1.i_hwdata = hwdata[1];
  assign bus0.i_hready = bus0.o_hreadyout;
  assign bus1.i_hready = bus1.o_hreadyout;
  assign rdy[0] = bus0.o_hreadyout; assign rdy[1] = bus1.o_hreadyout;
  assign resp[0] = bus0.o_hresp;    assign resp[1] = bus1.o_hresp;
  assign rdata[0] = bus0.o_hrdata;  assign rdata[1] = bus1.o_hrdata;

  ahb_slave_ram #(.DATA_WDT(32), .ADDR_WDT(AW), .WAIT_STATES(WS0)) u_dut0 (
    .i_hclk(i_hclk), .i_hreset_n(i_hreset_n), .bus(bus0));
  ahb_slave_ram #(.DATA_WDT(32), .ADDR_WDT(AW), .WAIT_STATES(WS1)) u_dut1 (
    .i_hclk(i_hclk), .i_hreset_n(i_hreset_n), .bus(bus1));

  typedef struct {
    bit [1:0]  trans;
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
    string     tag;
  } xfer_t;

  typedef struct {
    bit        wr;
    bit [31:0] rdata;
    bit [1:0]  resp;
    int        lows;
    string     tag;
  } exp_t;

  xfer_t       cmdq[$];
  exp_t        expq[$];
  logic [31:0] refmem [2][1 << AW];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic void push(input bit [1:0] t, input bit wr, input bit [31:0] a,
                               input bit [2:0] s, input bit [31:0] wd, input string tag);
    xfer_t x;
    x.trans = t; x.wr = wr; x.addr = a; x.size = s; x.wdata = wd; x.tag = tag;
    cmdq.push_back(x);
  endfunction

  // Reference behaviour of one accepted transfer; updates refmem for writes.
  function automatic exp_t model(input int d, input xfer_t x);
    exp_t e;
    bit   err;
    int   sz, ofs, idx;
    sz  = int'(x.size);
    ofs = int'(x.addr[1:0]);
    idx = int'(x.addr[11:2]);
`ifdef AHB_SLAVE_RAM_ERR_EN
    err = (sz > 2) || ((ofs % (1 << sz)) != 0) || (x.addr[31:12] != 0);
`else
    err = 1'b0;
    if (sz > 2) sz = 2;
    ofs = ofs - (ofs % (1 << sz));
`endif
    e.wr    = x.wr;
    e.tag   = x.tag;
    e.resp  = err ? 2'd1 : 2'd0;
    e.lows  = err ? 1 : ((d == 0) ? WS0 : WS1);
    e.rdata = '0;
    if (!err) begin
      if (x.wr) begin
        for (int b = 0; b < 4; b++)
          if (b >= ofs && b < ofs + (1 << sz)) refmem[d][idx][8*b +: 8] = x.wdata[8*b +: 8];
      end else begin
        e.rdata = refmem[d][idx];
      end
    end
    return e;
  endfunction

  // Pipelined master: presents the queue head as address phase while the previous data
  // phase completes. Must be entered just after a rising edge.
  task automatic run(input int d, input int exp_cyc);
    bit    have;
    xfer_t dp, x;
    exp_t  e;
    int    lows, cyc;
    have = 1'b0; lows = 0; cyc = 0;
    while ((cmdq.size() != 0 || have) && cyc < 200) begin
      if (cmdq.size() != 0) begin
        hsel[d] = 1'b1; htrans[d] = cmdq[0].trans; hwrite[d] = cmdq[0].wr;
        haddr[d] = cmdq[0].addr; hsize[d] = cmdq[0].size;
      end else begin
        hsel[d] = 1'b0; htrans[d] = 2'd0;
      end
      hwdata[d] = have ? dp.wdata : 32'h0;
      @(negedge i_hclk);
      if (have) begin
        if (!rdy[d]) begin
          lows++;
          chk({expq[0].tag, "_wait_resp"}, 32'(resp[d]), 32'(expq[0].resp));
          chk({expq[0].tag, "_wait_rdata"}, rdata[d], 32'h0);
        end else begin
          e = expq.pop_front();
          chk({e.tag, "_resp"}, 32'(resp[d]), 32'(e.resp));
          chk({e.tag, "_lows"}, lows, e.lows);
          if (!e.wr) chk({e.tag, "_rdata"}, rdata[d], e.rdata);
          have = 1'b0;
        end
      end
      if (rdy[d] && cmdq.size() != 0) begin
        x = cmdq.pop_front();
        if (x.trans[1]) begin
          have = 1'b1; dp = x; lows = 0;
          expq.push_back(model(d, x));
        end
      end
      @(posedge i_hclk); #1;
      cyc++;
    end
    if (cmdq.size() != 0 || have) begin
      chk("run_timeout", cmdq.size() + 32'(have), 0);
      cmdq.delete(); expq.delete();
    end
    if (exp_cyc > 0) chk("run_cycles", cyc, exp_cyc);
    hsel[d] = 1'b0; htrans[d] = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    hsel = '0; hwrite = '0; haddr = '0; hwdata = '0; htrans = '0; hsize = '0; hburst = 3'd0;
    #1 i_hreset_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rdy%0d", d), 32'(rdy[d]), 1);
      chk($sformatf("rst_resp%0d", d), 32'(resp[d]), 0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
    end
    #1 i_hreset_n = 1'b1;
    #0.5;
    chk("rel_rdy0", 32'(rdy[0]), 1);
    chk("rel_rdata0", rdata[0], 0);
    @(posedge i_hclk); #1;

    // Back-to-back write then read of the same word: 1 address + 2 data cycles.
    hburst = 3'd1;
    push(2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, "b2b_wr");
    push(2'd3, 1'b0, 32'h10, 3'd2, 32'h0,        "b2b_rd");
    run(0, 3);

    // Sub-word lane updates, with an IDLE slot in between.
    push(2'd2, 1'b1, 32'h10, 3'd2, 32'h11223344, "w_base");
    push(2'd2, 1'b1, 32'h13, 3'd0, 32'hAB000000, "w_byte");
    push(2'd2, 1'b0, 32'h10, 3'd2, 32'h0,        "r_byte");
    push(2'd0, 1'b0, 32'h10, 3'd2, 32'h0,        "idle");
    push(2'd2, 1'b1, 32'h10, 3'd1, 32'h00005566, "w_half");
    push(2'd2, 1'b0, 32'h10, 3'd2, 32'h0,        "r_half");
    push(2'd2, 1'b1, 32'h16, 3'd1, 32'h77660000, "w_hi16");
    push(2'd2, 1'b0, 32'h16, 3'd1, 32'h0,        "r_hi16");
    run(0, 0);

    // Wait states: single transfers and an INCR4 with a BUSY slot.
    push(2'd2, 1'b1, 32'h40, 3'd2, 32'h0BADF00D, "ws_wr");
    push(2'd2, 1'b0, 32'h40, 3'd2, 32'h0,        "ws_rd");
    run(1, 0);
    hburst = 3'd3;
    for (int i = 0; i < 4; i++) begin
      push((i == 0) ? 2'd2 : 2'd3, 1'b1, 32'h80 + 32'(4*i), 3'd2, 32'hA5000000 + 32'(i), "incr_wr");
      if (i == 1) push(2'd1, 1'b1, 32'h88, 3'd2, 32'h0, "busy_wr");
    end
    for (int i = 0; i < 4; i++) begin
      push((i == 0) ? 2'd2 : 2'd3, 1'b0, 32'h80 + 32'(4*i), 3'd2, 32'h0, "incr_rd");
      if (i == 2) push(2'd1, 1'b0, 32'h8C, 3'd2, 32'h0, "busy_rd");
    end
    run(1, 0);

    // Bad size / alignment / range: ERROR with the feature, aliasing/clamping without.
    hburst = 3'd0;
    push(2'd2, 1'b1, 32'h0,    3'd2, 32'hCAFEF00D, "e_base");
    push(2'd2, 1'b1, 32'h8,    3'd2, 32'h87654321, "e_base8");
    push(2'd2, 1'b1, 32'h2,    3'd2, 32'h12345678, "e_misal");
    push(2'd2, 1'b0, 32'h0,    3'd2, 32'h0,        "e_rd0");
    push(2'd2, 1'b1, 32'h1000, 3'd2, 32'h00001234, "e_range");
    push(2'd0, 1'b0, 32'h0,    3'd2, 32'h0,        "e_cancel");
    push(2'd2, 1'b0, 32'h0,    3'd2, 32'h0,        "e_rd1");
    push(2'd2, 1'b1, 32'h3,    3'd1, 32'hBEEF0000, "e_half");
    push(2'd2, 1'b0, 32'h0,    3'd2, 32'h0,        "e_rd2");
    push(2'd2, 1'b1, 32'h8,    3'd3, 32'h0F0F0F0F, "e_size");
    push(2'd2, 1'b0, 32'h8,    3'd2, 32'h0,        "e_rd8");
    push(2'd2, 1'b0, 32'h1008, 3'd2, 32'h0,        "e_rdhi");
    run(0, 0);
    push(2'd2, 1'b1, 32'h4,    3'd2, 32'h0C0FFEE0, "e1_base");
    push(2'd2, 1'b1, 32'h5,    3'd2, 32'hFFFFFFFF, "e1_misal");
    push(2'd2, 1'b0, 32'h4,    3'd2, 32'h0,        "e1_rd");
    run(1, 0);

    // Reset during a write data phase must drop the write.
    push(2'd2, 1'b1, 32'h30, 3'd2, 32'h55AA55AA, "rm_base");
    run(0, 0);
    hsel[0] = 1'b1; htrans[0] = 2'd2; hwrite[0] = 1'b1; haddr[0] = 32'h30; hsize[0] = 3'd2;
    @(posedge i_hclk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'd0; hwdata[0] = 32'hFFFFFFFF;
    #1 i_hreset_n = 1'b0;
    #1;
    chk("rm_rdy", 32'(rdy[0]), 1);
    chk("rm_resp", 32'(resp[0]), 0);
    chk("rm_rdata", rdata[0], 0);
    #1 i_hreset_n = 1'b1;
    @(posedge i_hclk); #1;
    push(2'd2, 1'b0, 32'h30, 3'd2, 32'h0, "rm_rd");
    run(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_slave_ram.md
# ahb_slave_ram

AMBA 2.0 AHB slave (responder) backed by an internal register-array memory, with configurable wait states and optional two-cycle ERROR responses. It is the target-side counterpart of the team's AHB master and sits behind the AHB decoder/multiplexor. It is used as a bench memory and as a small on-chip scratchpad.

## Interface
- DATA_WDT, 32: data bus width; legal values are 32 and 64.
- ADDR_WDT, 10: number of word-index bits; the memory holds 2^ADDR_WDT words.
- WAIT_STATES, 0: number of low o_hreadyout cycles inserted per OKAY data phase; range 0–15.
- i_hclk  in  1  AHB clock; all state changes on the rising edge.
- i_hreset_n  in  1  asynchronous, active-low reset.
- i_hsel  in  1  slave select from the decoder.
- i_haddr  in  32  address.
- i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- i_hwrite  in  1  1 = write.
- i_hsize  in  3  transfer size, 0 = byte.
- i_hburst  in  3  burst type; informational only, no behaviour depends on it.
- i_hwdata  in  DATA_WDT  write data, valid in the data phase.
- i_hready  in  1  global HREADY from the bus multiplexor.
- o_hrdata  out  DATA_WDT  read data.
- o_hreadyout  out  1  this slave's HREADY.
- o_hresp  out  2  OKAY=0, ERROR=1; SPLIT and RETRY are never driven.

## Operation
- Definitions:
  - OFS = log2(DATA_WDT/8), the byte-offset bit count.
  - Word index = i_haddr[OFS+ADDR_WDT-1:OFS].
  - Address-phase accept (ACC) = i_hsel & i_hready & i_htrans[1].
- On ACC the block registers address, size, write and the error flag, then enters the data phase.
- A cycle with i_hsel & i_hready & i_htrans is IDLE or BUSY is a zero-wait OKAY with no access.
- A cycle with i_hsel=0, or i_hready=0 outside an owned data phase, does nothing.
- States:
  - S_IDLE: no data phase owned; o_hreadyout=1, OKAY.
  - S_WAIT: counter runs; o_hreadyout=0, OKAY.
  - S_DATA: o_hreadyout=1, OKAY; the write is committed or the read data is driven.
  - S_ERR1: o_hreadyout=0, ERROR.
  - S_ERR2: o_hreadyout=1, ERROR.
- Transitions:
  - ACC, error flag set (macro only) → S_ERR1.
  - ACC, WAIT_STATES>0 → S_WAIT, counter loaded with WAIT_STATES-1.
  - ACC, WAIT_STATES=0 → S_DATA.
  - S_WAIT with counter 0 → S_DATA; otherwise the counter decrements.
  - S_ERR1 → S_ERR2.
  - S_DATA or S_ERR2: next state is decided by ACC or no-ACC in that same cycle (pipelined; S_IDLE if no ACC).
- Writes:
  - Committed at the clock edge that ends S_DATA, using i_hwdata.
  - Byte enables are derived from the registered size and address[OFS-1:0]; only the addressed lanes are updated.
- Reads:
  - o_hrdata = mem[registered index] during S_DATA.
  - o_hrdata = 0 in all other states.
- A write data phase followed immediately by a read of the same word returns the new data, because the commit precedes the read data phase.
- Memory contents are not reset.
- Error flag (macro only) is set when any of these holds:
  - i_hsize > OFS.
  - The address is not aligned to the size.
  - i_haddr[31:OFS+ADDR_WDT] != 0.
- Errored transfers never write; read data is 0.

## Timing
- Reset values: o_hreadyout=1, o_hresp=OKAY, o_hrdata=0, state S_IDLE, wait counter 0.
- Reset asserted mid data phase aborts it with no memory write.
- Data phase length is WAIT_STATES+1 cycles for OKAY transfers and exactly 2 cycles for ERROR.
- With WAIT_STATES=0, back-to-back NONSEQ/SEQ transfers complete one per cycle.
- The address phase of transfer N+1 is sampled in the final (o_hreadyout=1) cycle of transfer N.
- While this slave holds o_hreadyout=0, i_hready is low and the address inputs are ignored.
- If the master drives IDLE during S_ERR2 (cancelling a burst), it is accepted as IDLE: S_IDLE, OKAY.
- A BUSY inside a burst never starts a data phase and never delays the next SEQ.

## Configuration
- AHB_SLAVE_RAM_ERR_EN defined:
  - Error flag checking is active.
  - Illegal size, misaligned or out-of-range transfers get the two-cycle ERROR response.
- AHB_SLAVE_RAM_ERR_EN undefined:
  - S_ERR1 and S_ERR2 are removed and o_hresp is tied to OKAY.
  - Upper address bits are ignored, so addresses alias modulo the memory size.
  - Size is clamped to OFS and the low address bits are masked to the size alignment.

## Test plan
- Reset release → o_hreadyout=1, o_hresp=0, o_hrdata=0 with no clock edge needed.
- WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10, then SEQ read of 0x10 back-to-back → read data phase returns 0xDEADBEEF; 2 data phases in 2 cycles.
- WAIT_STATES=2: single word read → o_hreadyout low for exactly 2 cycles, then high with data; a BUSY mid-INCR4 adds no wait.
- Byte write 0xAB to 0x13 over word 0x11223344 at 0x10 → word reads 0xAB223344; halfword write 0x5566 to 0x10 → 0xAB225566.
- ERR_EN defined: word write to 0x02 (misaligned) → ERROR with o_hreadyout 0 then 1; word unchanged; next NONSEQ read is accepted in S_ERR2 and returns OKAY data.
- ERR_EN undefined: write 0x1234 to 0x1000 with ADDR_WDT=10 → read from 0x0 returns 0x1234, o_hresp always 0.
